// File: rtl/mul_bus_if.sv
// Strobe bus between the multiply-job initiator and the multiplier/GPIO peripheral.
// The initiator owns address, data and both strobes; the peripheral returns read data.
interface mul_bus_if;
  logic [15:0] bus_addr;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_addr,
    output bus_wr,
    output bus_rd,
    output bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr,
    input  bus_wr,
    input  bus_rd,
    input  bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/mul_bus_initiator.sv
// Runs one multiply job per start: write A1/A2, poll STATUS, read W and L, pulse done.
// Each bus transaction is SETUP+STROBE+HOLD clocks; start is ignored until the job returns to IDLE.
module mul_bus_initiator #(
  parameter int SETUP    = 1,
  parameter int STROBE   = 2,
  parameter int HOLD     = 1,
  parameter int POLL_GAP = 2,
  parameter int POLL_MAX = 1023
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic [23:0] a1,
  input  logic [23:0] a2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_w,
  output logic [31:0] result_l,
  output logic [1:0]  result_status,
  mul_bus_if.master   bus
);

  localparam logic [15:0] ADDR_A1     = 16'h01D8;
  localparam logic [15:0] ADDR_A2     = 16'h01E0;
  localparam logic [15:0] ADDR_W      = 16'h01E8;
  localparam logic [15:0] ADDR_L      = 16'h01F0;
  localparam logic [15:0] ADDR_STATUS = 16'h01F8;

  localparam int CMAX_A = (SETUP > STROBE) ? SETUP : STROBE;
  localparam int CMAX_B = (HOLD > POLL_GAP) ? HOLD : POLL_GAP;
  localparam int CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int PW     = $clog2(POLL_MAX + 1);

  localparam logic [CW-1:0] SET_LAST = CW'(SETUP - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STROBE - 1);
  localparam logic [CW-1:0] HLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [PW-1:0] POLL_LIMIT = PW'(POLL_MAX);

  typedef enum logic [2:0] {
    IDLE, WR_A1, WR_A2, POLL, GAP, RD_W, RD_L, DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_SET, PH_STB, PH_HLD
  } phase_t;

  state_t        state, state_n;
  phase_t        phase, phase_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] poll_cnt;
  logic [31:0]   rdata_q;
  logic [23:0]   a2_q;
  logic [15:0]   addr_q, addr_n;
  logic [31:0]   wdata_q, wdata_n;
  logic          accept;
  logic          launch;
  logic          poll_end;
  logic          timeout;
  logic          is_bus;
  logic          capture;

  assign is_bus  = (state == WR_A1) || (state == WR_A2) || (state == POLL) ||
                   (state == RD_W)  || (state == RD_L);
  // Read data is sampled on the same edge that drops the strobe.
  assign capture = is_bus && (phase == PH_STB) && (cnt == STB_LAST);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      phase   <= PH_SET;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      cnt     <= cnt_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
    end
  end

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    cnt_n    = cnt;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    accept   = 1'b0;
    launch   = 1'b0;
    poll_end = 1'b0;
    timeout  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = WR_A1;
          launch  = 1'b1;
        end
      end
      WR_A1, WR_A2, POLL, RD_W, RD_L: begin
        case (phase)
          PH_SET: begin
            if (cnt == SET_LAST) begin
              phase_n = PH_STB;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
          PH_STB: begin
            if (cnt == STB_LAST) begin
              phase_n = PH_HLD;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
          default: begin
            if (cnt == HLD_LAST) begin
              case (state)
                WR_A1: begin
                  state_n = WR_A2;
                  launch  = 1'b1;
                end
                WR_A2: begin
                  state_n = POLL;
                  launch  = 1'b1;
                end
                POLL: begin
                  poll_end = 1'b1;
                  if (rdata_q == 32'd1) begin
                    if (poll_cnt == POLL_LIMIT) begin
                      timeout = 1'b1;
                      state_n = DONE;
                    end else if (POLL_GAP > 0) begin
                      state_n = GAP;
                      phase_n = PH_SET;
                      cnt_n   = '0;
                    end else begin
                      state_n = POLL;
                      launch  = 1'b1;
                    end
                  end else begin
                    state_n = RD_W;
                    launch  = 1'b1;
                  end
                end
                RD_W: begin
                  state_n = RD_L;
                  launch  = 1'b1;
                end
                default: state_n = DONE;
              endcase
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
        endcase
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = POLL;
          launch  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Address/data only change when a new transaction begins; otherwise they hold.
    if (launch) begin
      phase_n = PH_SET;
      cnt_n   = '0;
      case (state_n)
        WR_A1: begin
          addr_n  = ADDR_A1;
          wdata_n = {8'h00, a1};
        end
        WR_A2: begin
          addr_n  = ADDR_A2;
          wdata_n = {8'h00, a2_q};
        end
        POLL: begin
          addr_n  = ADDR_STATUS;
          wdata_n = '0;
        end
        RD_W: begin
          addr_n  = ADDR_W;
          wdata_n = '0;
        end
        default: begin
          addr_n  = ADDR_L;
          wdata_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a2_q          <= '0;
      poll_cnt      <= '0;
      rdata_q       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result_w      <= '0;
      result_l      <= '0;
      result_status <= '0;
    end else begin
      busy <= (state_n != IDLE) && (state_n != DONE);
      done <= (state_n == DONE);
      if (accept) begin
        a2_q          <= a2;
        poll_cnt      <= '0;
        result_w      <= '0;
        result_l      <= '0;
        result_status <= '0;
      end else begin
        if (capture && (state == POLL)) begin
          rdata_q  <= bus.bus_rdata;
          poll_cnt <= poll_cnt + PW'(1);
        end
        if (capture && (state == RD_W)) result_w <= bus.bus_rdata;
        if (capture && (state == RD_L)) result_l <= bus.bus_rdata;
        if (timeout) begin
          result_status <= 2'd3;
          result_w      <= '0;
          result_l      <= '0;
        end else if (poll_end && (rdata_q != 32'd1)) begin
          result_status <= (rdata_q == 32'd2) ? 2'd2 : 2'd0;
        end
      end
    end
  end

  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_wr    = ((state == WR_A1) || (state == WR_A2)) && (phase == PH_STB);
  assign bus.bus_rd    = ((state == POLL) || (state == RD_W) || (state == RD_L)) &&
                         (phase == PH_STB);

endmodule
